// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   word_t / inst_t : 32-bit data and instruction words
//   if_state_t      : fetch FSM states (IF_HALT only reachable with IF_TIMEOUT_EN)
//   PC_STEP         : sequential PC increment
package if_fetch_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] inst_t;

  typedef enum logic [2:0] {
    IF_IDLE,
    IF_REQ,
    IF_FULL,
    IF_DROP,
    IF_HALT
  } if_state_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-bus req/ack interface.
//   ibus_req_o   : fetch request, held until ibus_ack_i
//   ibus_addr_o  : fetch address, stable while requesting
//   ibus_ack_i   : one-cycle acknowledge
//   ibus_rdata_i : fetched word, valid with ibus_ack_i
// master = fetch stage, slave = memory side.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic  ibus_req_o;
  word_t ibus_addr_o;
  logic  ibus_ack_i;
  word_t ibus_rdata_i;

  modport master (output ibus_req_o, ibus_addr_o, input ibus_ack_i, ibus_rdata_i);
  modport slave  (input ibus_req_o, ibus_addr_o, output ibus_ack_i, ibus_rdata_i);
endinterface

// File: rtl/if_pc_reg.sv
// Program counter register.
//   clk, rst       : clock, synchronous active-high reset (loads RESET_PC)
//   redirect_i     : load redirect_pc_i (wins over inc_i)
//   redirect_pc_i  : new PC
//   inc_i          : advance by PC_STEP (32-bit modulo)
//   pc_o           : current PC
module if_pc_reg
  import if_fetch_pkg::*;
#(
  parameter word_t RESET_PC = 32'hBFC0_0000
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  redirect_i,
  input  word_t redirect_pc_i,
  input  logic  inc_i,
  output word_t pc_o
);

  word_t pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack instruction bus,
// parks one word while ID stalls, and presents a registered {inst, pc, valid}.
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : ID cannot accept; hold inst_*_o
//   redirect_i      : flush and restart at redirect_pc_i (highest priority)
//   redirect_pc_i   : new PC
//   ibus            : instruction bus (if_fetch_if master)
//   inst_o/inst_pc_o/inst_valid_o : IF/ID boundary registers
//   fetch_err_o     : sticky bus-timeout flag
// Optional feature macro IF_TIMEOUT_EN: bus-wait timeout with HALT state;
// without it fetch_err_o is tied low.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter word_t       RESET_PC       = 32'hBFC0_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  word_t             redirect_pc_i,
  if_fetch_if.master        ibus,
  output inst_t             inst_o,
  output word_t             inst_pc_o,
  output logic              inst_valid_o,
  output logic              fetch_err_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("if_fetch: TIMEOUT_CYCLES must be within 1..255");
  end

  if_state_t state_q, state_d;
  inst_t     inst_q, inst_d, hold_inst_q, hold_inst_d;
  word_t     inst_pc_q, inst_pc_d, hold_pc_q, hold_pc_d;
  word_t     drop_addr_q, drop_addr_d;
  logic      inst_valid_q, inst_valid_d;
  logic      pc_inc;
  logic      slot_free;
  logic      req;
  word_t     pc;

  if_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inc_i         (pc_inc),
    .pc_o          (pc)
  );

  // After a redirect the PC already points at the new target, but the bus
  // must keep presenting the abandoned address until its ack arrives.
  assign req              = (state_q == IF_REQ) || (state_q == IF_DROP);
  assign ibus.ibus_req_o  = req;
  assign ibus.ibus_addr_o = (state_q == IF_DROP) ? drop_addr_q : pc;
  assign slot_free        = !inst_valid_q || !stall_i;

`ifdef IF_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    drop_addr_d  = drop_addr_q;
    pc_inc       = 1'b0;
`ifdef IF_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (ibus.ibus_ack_i) begin
          pc_inc = 1'b1;
          if (slot_free) begin
            inst_d       = ibus.ibus_rdata_i;
            inst_pc_d    = pc;
            inst_valid_d = 1'b1;
          end else begin
            hold_inst_d = ibus.ibus_rdata_i;
            hold_pc_d   = pc;
            state_d     = IF_FULL;
          end
        end else if (slot_free) begin
          inst_valid_d = 1'b0;
        end
      end
      IF_FULL: begin
        if (!stall_i) begin
          inst_d       = hold_inst_q;
          inst_pc_d    = hold_pc_q;
          inst_valid_d = 1'b1;
          state_d      = IF_REQ;
        end
      end
      IF_DROP: begin
        if (ibus.ibus_ack_i) begin
          state_d = IF_REQ;
        end
      end
      IF_HALT: begin
        if (slot_free) begin
          inst_valid_d = 1'b0;
        end
      end
      default: state_d = IF_IDLE;
    endcase

`ifdef IF_TIMEOUT_EN
    if (req && !ibus.ibus_ack_i) begin
      if (cnt_q == TIMEOUT_LAST) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = IF_HALT;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = '0;
    end
`endif

    // Redirect overrides everything above, including a same-cycle timeout.
    if (redirect_i) begin
      inst_valid_d = 1'b0;
      pc_inc       = 1'b0;
`ifdef IF_TIMEOUT_EN
      cnt_d        = '0;
      err_d        = 1'b0;
`endif
      if (state_q == IF_DROP) begin
        state_d = IF_DROP;
      end else if (state_q == IF_REQ && !ibus.ibus_ack_i) begin
        drop_addr_d = pc;
        state_d     = IF_DROP;
      end else begin
        state_d = IF_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_IDLE;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      drop_addr_q  <= '0;
`ifdef IF_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      drop_addr_q  <= drop_addr_d;
`ifdef IF_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
`ifdef IF_TIMEOUT_EN
  assign fetch_err_o  = err_q;
`else
  assign fetch_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: per-cycle vector table for the stall
// scenario, hand sequences for redirect corner cases, and a scoreboard of
// acked words checked when ID consumes them.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam word_t B = 32'hBFC0_0000;

  typedef struct {
    logic  inst;
    logic  pc_dummy;
  } unused_t;

  typedef struct {
    inst_t inst;
    word_t pc;
  } exp_t;

  typedef struct {
    logic  stall;
    logic  exp_req;
    word_t exp_addr;
    logic  exp_valid;
    word_t exp_pc;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  stall = 1'b0;
  logic  redirect = 1'b0;
  word_t redirect_pc = '0;
  inst_t inst;
  word_t inst_pc;
  logic  inst_valid;
  logic  fetch_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  bit          slave_en = 1'b1;
  bit          force_ack = 1'b0;
  bit          stale = 1'b0;
  word_t       exp_pc = B;
  exp_t        sbq[$];

  if_fetch_if ibus();

  if_fetch #(.RESET_PC(B), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .ibus          (ibus),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_valid_o  (inst_valid),
    .fetch_err_o   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // One clock cycle; entered and left at a falling edge. Acts as the bus
  // slave (ack after `lat` wait cycles) and runs the scoreboard.
  task automatic step();
    logic ack_now;
    exp_t e;
    ack_now = 1'b0;
    if (force_ack) begin
      ack_now = 1'b1;
    end else if (slave_en && ibus.ibus_req_o) begin
      if (wait_cnt >= lat) ack_now = 1'b1;
      else wait_cnt++;
    end
    ibus.ibus_ack_i   = ack_now;
    ibus.ibus_rdata_i = ack_now ? (ibus.ibus_addr_o ^ 32'hFFFF_FFFF) : 32'h0;

    if (inst_valid && !stall) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: actual valid pc %h, required no valid output", inst_pc);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_inst", inst, e.inst);
      end
    end

    if (ack_now && !force_ack) begin
      if (stale) begin
        stale = 1'b0;
      end else if (!redirect) begin
        chk("ack_addr", ibus.ibus_addr_o, exp_pc);
        sbq.push_back('{inst: exp_pc ^ 32'hFFFF_FFFF, pc: exp_pc});
        exp_pc += 32'd4;
      end
    end

    if (redirect) begin
      sbq.delete();
      exp_pc = redirect_pc;
      if (ibus.ibus_req_o && !ack_now) stale = 1'b1;
    end

    @(posedge clk);
    if (ack_now) wait_cnt = 0;
    @(negedge clk);
  endtask

  // Three reset cycles; leaves the bench at the falling edge of cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    force_ack = 1'b0;
    slave_en = 1'b1;
    lat = 0;
    ibus.ibus_ack_i = 1'b0;
    ibus.ibus_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, ibus.ibus_req_o}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    rst = 1'b0;
    sbq.delete();
    stale = 1'b0;
    wait_cnt = 0;
    exp_pc = B;
  endtask

  // Stop acking so the IF/ID register and hold buffer empty out, then
  // require that every scoreboarded word was delivered.
  task automatic drain(input string name);
    stall = 1'b0;
    redirect = 1'b0;
    slave_en = 1'b0;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
    chk(name, sbq.size(), 32'd0);
  endtask

  vec_t tv[13];

  initial begin
    // Zero-wait slave, stall held c4..c8: one word parks in FULL.
    tv[0]  = '{1'b0, 1'b0, B,             1'b0, 32'h0};
    tv[1]  = '{1'b0, 1'b1, B,             1'b0, 32'h0};
    tv[2]  = '{1'b0, 1'b1, B + 32'h04,    1'b1, B};
    tv[3]  = '{1'b0, 1'b1, B + 32'h08,    1'b1, B + 32'h04};
    tv[4]  = '{1'b1, 1'b1, B + 32'h0C,    1'b1, B + 32'h08};
    tv[5]  = '{1'b1, 1'b0, B + 32'h10,    1'b1, B + 32'h08};
    tv[6]  = '{1'b1, 1'b0, B + 32'h10,    1'b1, B + 32'h08};
    tv[7]  = '{1'b1, 1'b0, B + 32'h10,    1'b1, B + 32'h08};
    tv[8]  = '{1'b1, 1'b0, B + 32'h10,    1'b1, B + 32'h08};
    tv[9]  = '{1'b0, 1'b0, B + 32'h10,    1'b1, B + 32'h08};
    tv[10] = '{1'b0, 1'b1, B + 32'h10,    1'b1, B + 32'h0C};
    tv[11] = '{1'b0, 1'b1, B + 32'h14,    1'b1, B + 32'h10};
    tv[12] = '{1'b0, 1'b1, B + 32'h18,    1'b1, B + 32'h14};

    // Streaming and stall/park via the vector table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      stall = tv[i].stall;
      chk($sformatf("tv%0d_req", i), {31'b0, ibus.ibus_req_o}, {31'b0, tv[i].exp_req});
      chk($sformatf("tv%0d_addr", i), ibus.ibus_addr_o, tv[i].exp_addr);
      chk($sformatf("tv%0d_valid", i), {31'b0, inst_valid}, {31'b0, tv[i].exp_valid});
      if (tv[i].exp_valid) chk($sformatf("tv%0d_pc", i), inst_pc, tv[i].exp_pc);
      step();
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stream_valid", {31'b0, inst_valid}, 32'd1);
      chk("stream_pc", inst_pc, B + 32'h18 + 32'(4 * i));
      step();
    end
    drain("drain_stream");

    // Redirect while a 3-wait request is outstanding.
    do_reset();
    lat = 3;
    step();
    chk("t3_req_c1", {31'b0, ibus.ibus_req_o}, 32'd1);
    chk("t3_addr_c1", ibus.ibus_addr_o, B);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h8000_0100;
    chk("t3_addr_c2", ibus.ibus_addr_o, B);
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t3_drop_req", {31'b0, ibus.ibus_req_o}, 32'd1);
      chk("t3_drop_addr", ibus.ibus_addr_o, B);
      chk("t3_drop_valid", {31'b0, inst_valid}, 32'd0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("t3_new_req", {31'b0, ibus.ibus_req_o}, 32'd1);
      chk("t3_new_addr", ibus.ibus_addr_o, 32'h8000_0100);
      chk("t3_new_valid", {31'b0, inst_valid}, 32'd0);
      step();
    end
    chk("t3_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("t3_first_pc", inst_pc, 32'h8000_0100);
    drain("drain_t3");

    // Redirect + stall + ack together while FULL.
    do_reset();
    step();
    step();
    stall = 1'b1;
    step();
    chk("t4_full_req", {31'b0, ibus.ibus_req_o}, 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h0000_2000;
    force_ack = 1'b1;
    step();
    redirect = 1'b0;
    force_ack = 1'b0;
    stall = 1'b0;
    chk("t4_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4_req", {31'b0, ibus.ibus_req_o}, 32'd1);
    chk("t4_addr", ibus.ibus_addr_o, 32'h0000_2000);
    repeat (4) step();
    drain("drain_t4");

    // PC wrap at the top of the address space.
    do_reset();
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("t5_addr0", ibus.ibus_addr_o, 32'hFFFF_FFF8);
    chk("t5_valid0", {31'b0, inst_valid}, 32'd0);
    step();
    chk("t5_addr1", ibus.ibus_addr_o, 32'hFFFF_FFFC);
    chk("t5_pc1", inst_pc, 32'hFFFF_FFF8);
    step();
    chk("t5_addr2", ibus.ibus_addr_o, 32'h0000_0000);
    chk("t5_pc2", inst_pc, 32'hFFFF_FFFC);
    step();
    chk("t5_pc3", inst_pc, 32'h0000_0000);
    drain("drain_t5");

    // Slave never acks.
    do_reset();
    slave_en = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_req_wait", {31'b0, ibus.ibus_req_o}, 32'd1);
      chk("t6_err_wait", {31'b0, fetch_err}, 32'd0);
      step();
    end
`ifdef IF_TIMEOUT_EN
    chk("t6_req_halt", {31'b0, ibus.ibus_req_o}, 32'd0);
    chk("t6_err_halt", {31'b0, fetch_err}, 32'd1);
`else
    chk("t6_req_nohalt", {31'b0, ibus.ibus_req_o}, 32'd1);
    chk("t6_err_tied", {31'b0, fetch_err}, 32'd0);
`endif
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    chk("t6_err_clear", {31'b0, fetch_err}, 32'd0);
    chk("t6_req_after", {31'b0, ibus.ibus_req_o}, 32'd1);
`ifdef IF_TIMEOUT_EN
    chk("t6_addr_after", ibus.ibus_addr_o, 32'h0000_0100);
`else
    chk("t6_addr_after", ibus.ibus_addr_o, B);
`endif
    slave_en = 1'b1;
    repeat (4) step();
    drain("drain_t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
